// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI transmit path: event types, status nibbles,
// baud divisor and status-byte helpers.
package midi_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF = 2'b00,
        EV_NOTE_ON  = 2'b01,
        EV_CTRL     = 2'b10,
        EV_RSVD     = 2'b11
    } ev_type_e;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CTRL     = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SEND_STATUS = 3'd1,
        S_SEND_D1     = 3'd2,
        S_SEND_D2     = 3'd3,
        S_DONE        = 3'd4
    } msg_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Reserved type yields a zero nibble; callers never transmit it.
    function automatic logic [7:0] status_byte(input logic [1:0] ev_type, input logic [3:0] channel);
        logic [3:0] nib;
        case (ev_type_e'(ev_type))
            EV_NOTE_OFF: nib = ST_NOTE_OFF;
            EV_NOTE_ON:  nib = ST_NOTE_ON;
            EV_CTRL:     nib = ST_CTRL;
            default:     nib = 4'h0;
        endcase
        return {nib, channel};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART byte serializer. idle is also high during the final cycle of a
// stop bit so the next byte can be loaded with no gap on the line.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       idle,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    logic [CW-1:0] baud_cnt_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic          active_r;
    logic          tx_r;
    logic          last_tick_s;
    logic          load_s;

    assign last_tick_s = active_r && (bit_cnt_r == 4'd9) && (baud_cnt_r == BAUD_LAST);
    assign idle        = !active_r || last_tick_s;
    assign load_s      = load && idle;
    assign tx          = tx_r;

    // Shift register, bit/baud counters and the registered line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r   <= 1'b0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 10'h3FF;
            tx_r       <= 1'b1;
        end else begin
            tx_r <= active_r ? shift_r[0] : 1'b1;
            if (load_s) begin
                active_r   <= 1'b1;
                baud_cnt_r <= '0;
                bit_cnt_r  <= 4'd0;
                shift_r    <= {1'b1, byte_in, 1'b0};
            end else if (active_r) begin
                if (baud_cnt_r == BAUD_LAST) begin
                    baud_cnt_r <= '0;
                    shift_r    <= {1'b1, shift_r[9:1]};
                    bit_cnt_r  <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd9) begin
                        active_r <= 1'b0;
                    end
                end else begin
                    baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/midi_note_transmitter.sv
// MIDI OUT message builder and 8N1 transmitter at BAUD_RATE.
// Optional macro MIDI_RUNNING_STATUS_EN omits a status byte equal to the last one sent.
module midi_note_transmitter
    import midi_pkg::*;
#(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 31250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [1:0]  ev_type,
    input  logic [3:0]  ev_channel,
    input  logic [6:0]  ev_data1,
    input  logic [6:0]  ev_data2,
    output logic        midi_out,
    output logic        busy,
    output logic [15:0] msg_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

    msg_state_e  state_r, next_state_s;
    logic [1:0]  type_r;
    logic [3:0]  chan_r;
    logic [6:0]  d1_r, d2_r;
    logic        sent_r, sent_next_s;
    logic        ev_ready_r, busy_r;
    logic [15:0] msg_count_r;
    logic        accept_s, rs_hit_s, load_s, ser_idle_s;
    logic [7:0]  byte_s, status_s;

    assign accept_s  = ev_valid && ev_ready_r;
    assign status_s  = status_byte(type_r, chan_r);
    assign ev_ready  = ev_ready_r;
    assign busy      = busy_r;
    assign msg_count = msg_count_r;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_r;

    assign rs_hit_s = (status_byte(ev_type, ev_channel) == last_status_r);

    // Status of the most recently completed message.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_status_r <= 8'h00;
        end else if (state_r == S_DONE) begin
            last_status_r <= status_s;
        end
    end
`else
    assign rs_hit_s = 1'b0;
`endif

    // sent_r marks that the current state's byte is already in the serializer;
    // the next byte is then loaded on the serializer's final stop-bit cycle.
    always_comb begin
        next_state_s = state_r;
        sent_next_s  = sent_r;
        load_s       = 1'b0;
        byte_s       = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    sent_next_s = 1'b0;
                    if (ev_type == EV_RSVD) begin
                        next_state_s = S_IDLE;
                    end else if (rs_hit_s) begin
                        next_state_s = S_SEND_D1;
                    end else begin
                        next_state_s = S_SEND_STATUS;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_SEND_STATUS: begin
                if (ser_idle_s && !sent_r) begin
                    load_s      = 1'b1;
                    byte_s      = status_s;
                    sent_next_s = 1'b1;
                end else if (ser_idle_s) begin
                    load_s       = 1'b1;
                    byte_s       = {1'b0, d1_r};
                    next_state_s = S_SEND_D1;
                end else begin
                    next_state_s = S_SEND_STATUS;
                end
            end
            S_SEND_D1: begin
                if (ser_idle_s && !sent_r) begin
                    load_s      = 1'b1;
                    byte_s      = {1'b0, d1_r};
                    sent_next_s = 1'b1;
                end else if (ser_idle_s) begin
                    load_s       = 1'b1;
                    byte_s       = {1'b0, d2_r};
                    next_state_s = S_SEND_D2;
                end else begin
                    next_state_s = S_SEND_D1;
                end
            end
            S_SEND_D2: begin
                if (ser_idle_s) begin
                    next_state_s = S_DONE;
                    sent_next_s  = 1'b0;
                end else begin
                    next_state_s = S_SEND_D2;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State, event latch, handshake/busy flags and message counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            type_r      <= 2'b00;
            chan_r      <= 4'h0;
            d1_r        <= 7'h00;
            d2_r        <= 7'h00;
            sent_r      <= 1'b0;
            ev_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            msg_count_r <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            sent_r     <= sent_next_s;
            // Reserved events stay in IDLE yet still drop ready for one cycle.
            ev_ready_r <= (next_state_s == S_IDLE) && !accept_s;
            busy_r     <= (next_state_s != S_IDLE);
            if (accept_s) begin
                type_r <= ev_type;
                chan_r <= ev_channel;
                d1_r   <= ev_data1;
                d2_r   <= ev_data2;
            end
            if (state_r == S_DONE) begin
                msg_count_r <= msg_count_r + 16'd1;
            end
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .byte_in (byte_s),
        .idle    (ser_idle_s),
        .tx      (midi_out)
    );

endmodule

// File: tb/tb_midi_note_transmitter.sv
// Directed, table-driven bench for midi_note_transmitter at 10 clk/bit.
module tb_midi_note_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_type;
    logic [3:0]  ev_channel;
    logic [6:0]  ev_data1;
    logic [6:0]  ev_data2;
    logic        midi_out;
    logic        busy;
    logic [15:0] msg_count;

    int checks   = 0;
    int failures = 0;

    localparam int BYTE_CLKS = 100;

    typedef struct {
        logic [1:0] t;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         cnt;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    midi_note_transmitter #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_type    (ev_type),
        .ev_channel (ev_channel),
        .ev_data1   (ev_data1),
        .ev_data2   (ev_data2),
        .midi_out   (midi_out),
        .busy       (busy),
        .msg_count  (msg_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after the accepting edge.
    function automatic logic exp_line(input int k, input int n, input logic [7:0] b0,
                                      input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bb;
        int idx, bi, bit_i;
        if (k < 2) return 1'b1;
        idx = k - 2;
        if (idx >= BYTE_CLKS * n) return 1'b1;
        bi    = idx / BYTE_CLKS;
        bit_i = (idx % BYTE_CLKS) / 10;
        bb    = (bi == 0) ? b0 : ((bi == 1) ? b1 : b2);
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        return bb[bit_i-1];
    endfunction

    // Present an event and return 1 time unit after the accepting edge.
    task automatic send_event(input logic [1:0] t, input logic [3:0] ch,
                              input logic [6:0] d1, input logic [6:0] d2);
        int w;
        @(negedge clk);
        ev_type    = t;
        ev_channel = ch;
        ev_data1   = d1;
        ev_data2   = d2;
        ev_valid   = 1'b1;
        w = 0;
        while (ev_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", {31'd0, (w < 50)}, 32'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] d1,
                           input logic [6:0] d2, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input bit jam);
        logic line_a[400];
        logic rdy_a[400];
        logic bsy_a[400];
        logic [7:0] got, want;
        int total, mism, rise;
        total = 2 + BYTE_CLKS * n + 15;
        send_event(t, ch, d1, d2);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            line_a[k] = midi_out;
            rdy_a[k]  = ev_ready;
            bsy_a[k]  = busy;
            if (jam && k < 1 + BYTE_CLKS * n) begin
                ev_valid   = 1'b1;
                ev_type    = 2'($urandom_range(3, 0));
                ev_channel = 4'($urandom_range(15, 0));
                ev_data1   = 7'($urandom_range(127, 0));
                ev_data2   = 7'($urandom_range(127, 0));
            end else begin
                ev_valid = 1'b0;
            end
        end
        mism = 0;
        for (int k = 0; k < total; k++) begin
            if (line_a[k] !== exp_line(k, n, b0, b1, b2)) mism++;
        end
        chk("line_wave", mism, 32'd0);
        for (int i = 0; i < n; i++) begin
            got = 8'h00;
            for (int j = 0; j < 8; j++) got[j] = line_a[2 + BYTE_CLKS * i + 10 * (j + 1) + 5];
            want = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
            chk($sformatf("byte%0d", i), {24'd0, got}, {24'd0, want});
        end
        rise = -1;
        for (int k = 0; k < total; k++) begin
            if (rise < 0 && rdy_a[k] === 1'b1) rise = k;
        end
        chk("ready_low_cycles", rise, 2 + BYTE_CLKS * n);
        mism = 0;
        for (int k = 0; k < total; k++) begin
            if (bsy_a[k] !== !rdy_a[k]) mism++;
        end
        chk("busy_vs_ready", mism, 32'd0);
    endtask

    initial begin
        logic rdy_a[6];
        int mism_line, mism_busy;
        rst        = 1'b1;
        ev_valid   = 1'b0;
        ev_type    = 2'b00;
        ev_channel = 4'h0;
        ev_data1   = 7'h00;
        ev_data2   = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_midi_out", {31'd0, midi_out}, 32'd1);
        chk("reset_ev_ready", {31'd0, ev_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_msg_count", {16'd0, msg_count}, 32'd0);

        vecs[0] = '{2'b01, 4'h0, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64, 1};
`ifdef MIDI_RUNNING_STATUS_EN
        vecs[1] = '{2'b01, 4'h0, 7'h40, 7'h00, 2, 8'h40, 8'h00, 8'h00, 2};
`else
        vecs[1] = '{2'b01, 4'h0, 7'h40, 7'h00, 3, 8'h90, 8'h40, 8'h00, 2};
`endif
        vecs[2] = '{2'b10, 4'hF, 7'h07, 7'h7F, 3, 8'hBF, 8'h07, 8'h7F, 3};
        vecs[3] = '{2'b00, 4'h3, 7'h7F, 7'h40, 3, 8'h83, 8'h7F, 8'h40, 4};
        vecs[4] = '{2'b11, 4'h3, 7'h01, 7'h02, 0, 8'h00, 8'h00, 8'h00, 4};
`ifdef MIDI_RUNNING_STATUS_EN
        vecs[5] = '{2'b00, 4'h3, 7'h01, 7'h02, 2, 8'h01, 8'h02, 8'h00, 5};
`else
        vecs[5] = '{2'b00, 4'h3, 7'h01, 7'h02, 3, 8'h83, 8'h01, 8'h02, 5};
`endif

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].n == 0) begin
                send_event(vecs[i].t, vecs[i].ch, vecs[i].d1, vecs[i].d2);
                mism_line = 0;
                mism_busy = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    rdy_a[k] = ev_ready;
                    if (midi_out !== 1'b1) mism_line++;
                    if (busy !== 1'b0) mism_busy++;
                end
                chk("rsvd_line_idle", mism_line, 32'd0);
                chk("rsvd_busy_low", mism_busy, 32'd0);
                chk("rsvd_ready_drop", {31'd0, rdy_a[0]}, 32'd0);
                chk("rsvd_ready_back", {31'd0, rdy_a[1]}, 32'd1);
            end else begin
                run_msg(vecs[i].t, vecs[i].ch, vecs[i].d1, vecs[i].d2, vecs[i].n,
                        vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b0);
            end
            chk($sformatf("msg_count_v%0d", i), {16'd0, msg_count}, vecs[i].cnt);
        end

        // Inputs churn while busy; only the latched event goes out.
        run_msg(2'b01, 4'h0, 7'h0A, 7'h14, 3, 8'h90, 8'h0A, 8'h14, 1'b1);
        chk("jam_msg_count", {16'd0, msg_count}, 32'd6);

        // Reset during data bit 0 of the second byte, then resend the same note.
        send_event(2'b01, 4'h0, 7'h3C, 7'h64);
        for (int k = 0; k <= 117; k++) @(negedge clk);
        chk("pre_reset_line", {31'd0, midi_out}, 32'd0);
        chk("pre_reset_count", {16'd0, msg_count}, 32'd6);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_midi_out", {31'd0, midi_out}, 32'd1);
        chk("post_reset_ev_ready", {31'd0, ev_ready}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_count", {16'd0, msg_count}, 32'd0);
        rst = 1'b0;
        run_msg(2'b01, 4'h0, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
        chk("resend_msg_count", {16'd0, msg_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
